board_tx_formatter: RTL and testbench

//   Renders the 3x3 tic-tac-toe board, cursor and side-to-move as an ASCII text

---
 rtl/board_tx_formatter.sv | 243 ++++++++++++++++++++++++
 tb/tb_board_tx_formatter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_tx_formatter.sv
// board_tx_formatter
//   Renders a 3x3 tic-tac-toe board, cursor and side-to-move as an ASCII text
//   frame and streams it one byte at a time to a UART transmitter.
//
//   Frame layout:
//     [ESC '[' 'H']                      optional home-cursor prefix
//     3 rows of: s0 c0 s1 c1 s2 c2 s3 CR LF
//     status:    'X'|'O' CR LF
//   A separator is ' ' except around the cursor cell, which is bracketed.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   render_req  request one frame (level sampled each cycle)
//   board[17:0] cell i = board[2i+1:2i], row-major; 00 empty, 01 X, 10 O, 11 invalid
//   cursor[3:0] selected cell 0..8; 9..15 shows no cursor
//   turn        side to move: 0 = X, 1 = O
//   tx_data     byte to transmit
//   tx_valid    tx_data is valid
//   tx_ready    transmitter accepts the byte this cycle
//   busy        a frame is in progress (including the DONE cycle)
//   frame_done  one-cycle pulse after the last byte of a frame is accepted
//   state_dbg   current FSM state, for observation only
//
// Handshake: a byte transfers on a cycle where tx_valid & tx_ready. tx_valid,
// once raised, stays high with tx_data stable until that transfer happens; the
// following byte (if any) is presented the very next cycle.
module board_tx_formatter #(
  parameter bit         CLEAR_SCREEN = 1'b1,
  parameter logic [7:0] EMPTY_CHAR   = 8'h2E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        render_req,
  input  logic [17:0] board,
  input  logic [3:0]  cursor,
  input  logic        turn,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ROWS   = 3'd2,
    S_STATUS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam state_t START_STATE = CLEAR_SCREEN ? S_CLEAR : S_ROWS;

  state_t      state, next_state;
  logic [17:0] snap_board;
  logic [3:0]  snap_cursor;
  logic        snap_turn;
  logic        pending;
  logic [3:0]  byte_idx;   // position within the current section, 0..8
  logic [1:0]  row_idx;    // 0..2, held at 2 through STATUS

  logic        accept;
  logic        last_in_section;
  logic        capture;

  // Cursor location decoded from the frozen snapshot
  logic        cur_on;
  logic [1:0]  cur_row;
  logic [1:0]  cur_col;

  logic [3:0]  cell_sel;
  logic [4:0]  cell_lo;
  logic [1:0]  cell_code;
  logic [1:0]  sep_j;

  function automatic logic [7:0] cell_char(input logic [1:0] code);
    case (code)
      2'b00:   cell_char = EMPTY_CHAR;
      2'b01:   cell_char = 8'h58;
      2'b10:   cell_char = 8'h4F;
      default: cell_char = 8'h3F;
    endcase
  endfunction

  assign accept = tx_valid & tx_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state      = state;
    last_in_section = 1'b0;
    capture         = 1'b0;
    case (state)
      S_IDLE: begin
        if (render_req) begin
          capture    = 1'b1;
          next_state = START_STATE;
        end
      end
      S_CLEAR: begin
        last_in_section = (byte_idx == 4'd2);
        if (accept && last_in_section) next_state = S_ROWS;
      end
      S_ROWS: begin
        last_in_section = (byte_idx == 4'd8);
        if (accept && last_in_section && row_idx == 2'd2) next_state = S_STATUS;
      end
      S_STATUS: begin
        last_in_section = (byte_idx == 4'd2);
        if (accept && last_in_section) next_state = S_DONE;
      end
      S_DONE: begin
        // A request arriving in the DONE cycle itself is merged with pending.
        if (pending || render_req) begin
          capture    = 1'b1;
          next_state = START_STATE;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, snapshot, pending flag and indices
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      snap_board  <= '0;
      snap_cursor <= '0;
      snap_turn   <= 1'b0;
      pending     <= 1'b0;
      byte_idx    <= '0;
      row_idx     <= '0;
    end else begin
      state <= next_state;

      if (capture) begin
        snap_board  <= board;
        snap_cursor <= cursor;
        snap_turn   <= turn;
      end

      // DONE always consumes the pending request (or there was none).
      if (state == S_DONE) pending <= 1'b0;
      else if (state != S_IDLE && render_req) pending <= 1'b1;

      if (capture) begin
        byte_idx <= '0;
        row_idx  <= '0;
      end else if (accept) begin
        if (last_in_section) begin
          byte_idx <= '0;
          if (state == S_ROWS && row_idx != 2'd2) row_idx <= row_idx + 2'd1;
        end else begin
          byte_idx <= byte_idx + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte generation
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_on  = 1'b1;
    cur_row = 2'd0;
    cur_col = 2'd0;
    case (snap_cursor)
      4'd0: begin cur_row = 2'd0; cur_col = 2'd0; end
      4'd1: begin cur_row = 2'd0; cur_col = 2'd1; end
      4'd2: begin cur_row = 2'd0; cur_col = 2'd2; end
      4'd3: begin cur_row = 2'd1; cur_col = 2'd0; end
      4'd4: begin cur_row = 2'd1; cur_col = 2'd1; end
      4'd5: begin cur_row = 2'd1; cur_col = 2'd2; end
      4'd6: begin cur_row = 2'd2; cur_col = 2'd0; end
      4'd7: begin cur_row = 2'd2; cur_col = 2'd1; end
      4'd8: begin cur_row = 2'd2; cur_col = 2'd2; end
      default: cur_on = 1'b0;
    endcase
  end

  // Odd positions 1,3,5 are cells (column = idx[2:1]); even positions 0..6
  // are separators s0..s3 (index = idx[2:1]).
  always_comb begin
    sep_j     = byte_idx[2:1];
    cell_sel  = ({2'b00, row_idx} * 4'd3) + {2'b00, byte_idx[2:1]};
    cell_lo   = {cell_sel, 1'b0};
    cell_code = snap_board[cell_lo +: 2];
  end

  always_comb begin
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    state_dbg  = state;
    case (state)
      S_CLEAR: begin
        tx_valid = 1'b1;
        case (byte_idx)
          4'd0:    tx_data = 8'h1B;
          4'd1:    tx_data = 8'h5B;
          default: tx_data = 8'h48;
        endcase
      end
      S_ROWS: begin
        tx_valid = 1'b1;
        case (byte_idx)
          4'd7: tx_data = 8'h0D;
          4'd8: tx_data = 8'h0A;
          default: begin
            if (byte_idx[0]) begin
              tx_data = cell_char(cell_code);
            end else if (cur_on && cur_row == row_idx && sep_j == cur_col) begin
              tx_data = 8'h5B;
            end else if (cur_on && cur_row == row_idx &&
                         {1'b0, sep_j} == ({1'b0, cur_col} + 3'd1)) begin
              tx_data = 8'h5D;
            end else begin
              tx_data = 8'h20;
            end
          end
        endcase
      end
      S_STATUS: begin
        tx_valid = 1'b1;
        case (byte_idx)
          4'd0:    tx_data = snap_turn ? 8'h4F : 8'h58;
          4'd1:    tx_data = 8'h0D;
          default: tx_data = 8'h0A;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_tx_formatter.sv
// Testbench for board_tx_formatter (CLEAR_SCREEN=1, EMPTY_CHAR='.').
// Stimulus pushes expected bytes (and a frame_done marker, bit 8 set) into
// exp_q; an independent monitor pops on every accepted byte / frame_done.
module tb_board_tx_formatter;

  logic        clk;
  logic        reset;
  logic        render_req;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic [2:0]  state_dbg;

  logic [8:0]  exp_q[$];
  int          n_vec;
  int          n_err;
  int          byte_cnt;
  logic        rand_ready;
  logic        ready_level;
  logic [7:0]  t1_bytes [33];

  localparam logic [8:0] DONE_MARK = 9'h100;

  board_tx_formatter #(.CLEAR_SCREEN(1'b1), .EMPTY_CHAR(8'h2E)) dut (
    .clk        (clk),
    .reset      (reset),
    .render_req (render_req),
    .board      (board),
    .cursor     (cursor),
    .turn       (turn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / ready generation
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_cell(input logic [1:0] code);
    case (code)
      2'b00:   return 8'h2E;
      2'b01:   return 8'h58;
      2'b10:   return 8'h4F;
      default: return 8'h3F;
    endcase
  endfunction

  // Reference frame builder, written row-by-row from the text layout.
  task automatic push_frame(input logic [17:0] b, input logic [3:0] c, input logic t);
    logic [7:0] s [4];
    int cr, cc;
    exp_q.push_back(9'h01B);
    exp_q.push_back(9'h05B);
    exp_q.push_back(9'h048);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) s[k] = 8'h20;
      if (c <= 4'd8) begin
        cr = int'(c) / 3;
        cc = int'(c) % 3;
        if (cr == r) begin
          s[cc]     = 8'h5B;
          s[cc + 1] = 8'h5D;
        end
      end
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back({1'b0, s[j]});
        exp_q.push_back({1'b0, model_cell(b[2*(3*r+j) +: 2])});
      end
      exp_q.push_back({1'b0, s[3]});
      exp_q.push_back(9'h00D);
      exp_q.push_back(9'h00A);
    end
    exp_q.push_back(t ? 9'h04F : 9'h058);
    exp_q.push_back(9'h00D);
    exp_q.push_back(9'h00A);
    exp_q.push_back(DONE_MARK);
  endtask

  task automatic push_t1;
    for (int i = 0; i < 33; i++) exp_q.push_back({1'b0, t1_bytes[i]});
    exp_q.push_back(DONE_MARK);
  endtask

  // Pulse render_req for one sampling edge N, then check the first byte is
  // presented in cycle N+1.
  task automatic start_frame(input string name);
    @(posedge clk); #1 render_req = 1'b1;
    @(posedge clk); #1 render_req = 1'b0;
    @(negedge clk);
    check({name, "_first_valid"}, 32'(tx_valid), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic pulse_req;
    @(posedge clk); #1 render_req = 1'b1;
    @(posedge clk); #1 render_req = 1'b0;
  endtask

  // Counts tx_valid cycles until frame_done; an expired bound is a failure.
  task automatic wait_frame_done(input string name, input int bound, output int vcnt);
    logic seen;
    seen = 1'b0;
    vcnt = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else if (tx_valid) vcnt++;
    end
    check({name, "_frame_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int bound);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (byte_cnt >= target) ok = 1'b1;
    end
    check("wait_bytes", 32'(ok), 32'd1);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic any_valid;
    any_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_valid || busy || frame_done) any_valid = 1'b1;
    end
    check({name, "_quiet"}, 32'(any_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       last_accept;
    logic [8:0] exp;
    prev_stall  = 1'b0;
    prev_data   = 8'h00;
    last_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall  = 1'b0;
        last_accept = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (frame_done) begin
          check("done_after_last_byte", 32'(last_accept), 32'd1);
          check("done_valid_low", 32'(tx_valid), 32'd0);
          if (exp_q.size() == 0) check("unexpected_frame_done", 32'd1, 32'd0);
          else begin
            exp = exp_q.pop_front();
            check("frame_done_order", 32'(DONE_MARK), 32'(exp));
          end
        end
        if (tx_valid && tx_ready) begin
          byte_cnt++;
          if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF);
          else begin
            exp = exp_q.pop_front();
            check("byte", {23'd0, 1'b0, tx_data}, 32'(exp));
          end
        end
        prev_stall  = tx_valid && !tx_ready;
        prev_data   = tx_data;
        last_accept = tx_valid && tx_ready;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int vcnt;
    int base;
    n_vec = 0;
    n_err = 0;
    byte_cnt = 0;
    rand_ready = 1'b0;
    ready_level = 1'b1;
    reset = 1'b1;
    render_req = 1'b0;
    board = '0;
    cursor = 4'd0;
    turn = 1'b0;
    t1_bytes = '{8'h1B, 8'h5B, 8'h48,
                 8'h20, 8'h2E, 8'h20, 8'h2E, 8'h20, 8'h2E, 8'h20, 8'h0D, 8'h0A,
                 8'h20, 8'h2E, 8'h5B, 8'h2E, 8'h5D, 8'h2E, 8'h20, 8'h0D, 8'h0A,
                 8'h20, 8'h2E, 8'h20, 8'h2E, 8'h20, 8'h2E, 8'h20, 8'h0D, 8'h0A,
                 8'h58, 8'h0D, 8'h0A};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // T1: empty board, cursor centre, X to move, ready tied high
    board = '0; cursor = 4'd4; turn = 1'b0;
    push_t1();
    start_frame("t1");
    wait_frame_done("t1", 100, vcnt);
    // 33 consecutive valid cycles: first one counted in start_frame
    check("t1_valid_cycles", 32'(vcnt), 32'd32);
    expect_quiet("t1", 3);

    // T2: same frame with random backpressure
    rand_ready = 1'b1;
    push_t1();
    start_frame("t2");
    wait_frame_done("t2", 1000, vcnt);
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    // T3: cursor corners and off-board cursor
    board = 18'b01_10_00_10_01_00_00_01_10;
    cursor = 4'd0;
    push_frame(board, cursor, 1'b0);
    start_frame("t3a");
    wait_frame_done("t3a", 100, vcnt);
    cursor = 4'd8;
    push_frame(board, cursor, 1'b0);
    start_frame("t3b");
    wait_frame_done("t3b", 100, vcnt);
    cursor = 4'd12;
    push_frame(board, cursor, 1'b0);
    start_frame("t3c");
    wait_frame_done("t3c", 100, vcnt);

    // T4: all four cell codes, O to move
    board = 18'b11_10_01_00_00_00_00_00_00;
    cursor = 4'd9;
    turn = 1'b1;
    push_frame(board, cursor, turn);
    start_frame("t4");
    wait_frame_done("t4", 100, vcnt);
    repeat (2) @(negedge clk);

    // T5: snapshot frozen mid-frame; two merged requests -> one extra frame
    board = 18'h0; cursor = 4'd4; turn = 1'b0;
    base = byte_cnt;
    push_frame(board, cursor, turn);
    start_frame("t5");
    wait_bytes(base + 5, 100);
    @(posedge clk); #1 board = 18'b10_10_10_01_01_01_11_11_11; cursor = 4'd2; turn = 1'b1;
    push_frame(board, cursor, turn);
    pulse_req();
    repeat (2) @(posedge clk);
    pulse_req();
    wait_frame_done("t5a", 100, vcnt);
    @(negedge clk);
    check("t5_back_to_back_valid", 32'(tx_valid), 32'd1);
    check("t5_back_to_back_busy", 32'(busy), 32'd1);
    wait_frame_done("t5b", 100, vcnt);
    expect_quiet("t5", 10);

    // T6: reset mid-frame with a pending request, then a clean restart
    board = '0; cursor = 4'd4; turn = 1'b0;
    base = byte_cnt;
    push_frame(board, cursor, turn);
    start_frame("t6");
    wait_bytes(base + 4, 100);
    pulse_req();
    wait_bytes(base + 10, 100);
    @(posedge clk); #1 reset = 1'b1; ready_level = 1'b0; exp_q.delete();
    @(posedge clk); #1 reset = 1'b0; ready_level = 1'b1;
    @(negedge clk);
    check("t6_reset_valid", 32'(tx_valid), 32'd0);
    check("t6_reset_busy", 32'(busy), 32'd0);
    check("t6_reset_done", 32'(frame_done), 32'd0);
    expect_quiet("t6", 10);
    push_t1();
    start_frame("t6r");
    wait_frame_done("t6r", 100, vcnt);
    check("t6r_valid_cycles", 32'(vcnt), 32'd32);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
